// File: rtl/gpu_req_pkg.sv
// gpu_req_pkg: command layout, response record and command builder shared by the GPU RAM read requester.
package gpu_req_pkg;
    localparam int CMD_RD_VALID_BIT = 0;
    localparam int CMD_TAG_LSB      = 8;
    localparam int CMD_TAG_MSB      = 15;

    typedef struct packed {
        logic [15:0] data;
        logic [19:0] addr;
        logic [7:0]  tag;
    } rsp_t;

    function automatic logic [31:0] mk_cmd(input logic [7:0] tag);
        logic [31:0] c;
        c = '0;
        c[CMD_TAG_MSB:CMD_TAG_LSB] = tag;
        c[CMD_RD_VALID_BIT] = 1'b1;
        return c;
    endfunction
endpackage

// File: rtl/gpu_req_fifo.sv
// gpu_req_fifo: synchronous FIFO with occupancy count; push when full is dropped, pop when empty is ignored.
module gpu_req_fifo #(
    parameter int W     = 44,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [W-1:0]               i_din,
    input  logic                       i_pop,
    output logic [W-1:0]               o_dout,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_pop && r_count != '0;
    assign w_push = i_push && (r_count != (AW+1)'(DEPTH) || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd];
    assign o_count = r_count;
endmodule

// File: rtl/gpu_ram_port_requester.sv
// gpu_ram_port_requester: read initiator for one slot of the time-multiplexed GPU RAM with in-order tagged responses.
// Define GPU_REQ_RETCHECK_EN to check every return against the issue order and raise a sticky err_flag.
module gpu_ram_port_requester
    import gpu_req_pkg::*;
#(
    parameter int RSP_DEPTH = 4,
    parameter int PC_LAST   = 4,
    parameter int RET_SLOT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  pc_ena_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_tag,
    output logic [19:0] ram_addr_out,
    output logic [31:0] ram_cmd_out,
    input  logic [19:0] ram_addr_in,
    input  logic [31:0] ram_cmd_in,
    input  logic [15:0] ram_data_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [19:0] rsp_addr,
    output logic [7:0]  rsp_tag,
    output logic        err_flag
);
    localparam int CW = $clog2(RSP_DEPTH) + 1;

    logic          r_hold_valid;
    logic [19:0]   r_hold_addr;
    logic [7:0]    r_hold_tag;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] w_fifo_count;
    logic          w_accept;
    logic          w_issue_slot;
    logic          w_issue;
    logic          w_ret;
    logic          w_ret_ok;
    logic          w_unused;
    rsp_t          w_rsp_in;
    rsp_t          w_rsp_out;

    // Credits cover both in-flight reads and queued responses, so a return always finds FIFO space.
    assign req_ready    = !reset && !r_hold_valid &&
                          ({1'b0, r_outstanding} + {1'b0, w_fifo_count} < (CW+1)'(RSP_DEPTH));
    assign w_accept     = req_valid && req_ready;
    assign w_issue_slot = pc_ena_in == 4'(PC_LAST);
    assign w_issue      = w_issue_slot && r_hold_valid;
    assign w_ret        = pc_ena_in == 4'(RET_SLOT) && ram_cmd_in[CMD_RD_VALID_BIT];
    assign w_ret_ok     = w_ret && r_outstanding != '0;
    assign w_rsp_in     = '{data: ram_data_in, addr: ram_addr_in, tag: ram_cmd_in[CMD_TAG_MSB:CMD_TAG_LSB]};
    assign w_unused     = ^{ram_cmd_in[31:CMD_TAG_MSB+1], ram_cmd_in[CMD_TAG_LSB-1:CMD_RD_VALID_BIT+1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_valid  <= 1'b0;
            r_hold_addr   <= '0;
            r_hold_tag    <= '0;
            r_outstanding <= '0;
            ram_addr_out  <= '0;
            ram_cmd_out   <= '0;
        end else begin
            if (w_issue_slot) ram_cmd_out <= r_hold_valid ? mk_cmd(r_hold_tag) : '0;
            if (w_issue) ram_addr_out <= r_hold_addr;
            if (w_issue) begin
                r_hold_valid <= 1'b0;
            end else if (w_accept) begin
                r_hold_valid <= 1'b1;
                r_hold_addr  <= req_addr;
                r_hold_tag   <= req_tag;
            end
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_ret_ok);
        end
    end

    gpu_req_fifo #(.W($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_push  (w_ret_ok),
        .i_din   (w_rsp_in),
        .i_pop   (rsp_ready),
        .o_dout  (w_rsp_out),
        .o_count (w_fifo_count)
    );

    assign rsp_valid = w_fifo_count != '0;
    assign rsp_data  = w_rsp_out.data;
    assign rsp_addr  = w_rsp_out.addr;
    assign rsp_tag   = w_rsp_out.tag;

`ifdef GPU_REQ_RETCHECK_EN
    logic [27:0]   w_shadow_head;
    logic [CW-1:0] w_shadow_count;
    logic          w_mismatch;
    logic          r_err;

    gpu_req_fifo #(.W(28), .DEPTH(RSP_DEPTH)) u_shadow_fifo (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_push  (w_issue),
        .i_din   ({r_hold_addr, r_hold_tag}),
        .i_pop   (w_ret_ok),
        .o_dout  (w_shadow_head),
        .o_count (w_shadow_count)
    );

    assign w_mismatch = w_shadow_count == '0 || w_shadow_head != {w_rsp_in.addr, w_rsp_in.tag};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_err <= 1'b0;
        else if ((w_ret && !w_ret_ok) || (w_ret_ok && w_mismatch)) r_err <= 1'b1;
    end

    assign err_flag = r_err;
`else
    assign err_flag = 1'b0;
`endif
endmodule

// File: tb/tb_gpu_ram_port_requester.sv
// tb_gpu_ram_port_requester: drives the pixel phase, models a 3-pixel RAM slot and checks responses against a transaction-level model.
module tb_gpu_ram_port_requester;
    import gpu_req_pkg::*;

    localparam int RSP_DEPTH = 4;
    localparam int PC_LAST   = 4;
    localparam int RET_SLOT  = 1;
`ifdef GPU_REQ_RETCHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  pc = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [19:0] req_addr = '0;
    logic [7:0]  req_tag = '0;
    logic [19:0] ram_addr_out;
    logic [31:0] ram_cmd_out;
    logic [19:0] ram_addr_in = '0;
    logic [31:0] ram_cmd_in = '0;
    logic [15:0] ram_data_in = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [19:0] rsp_addr;
    logic [7:0]  rsp_tag;
    logic        err_flag;

    gpu_ram_port_requester #(.RSP_DEPTH(RSP_DEPTH), .PC_LAST(PC_LAST), .RET_SLOT(RET_SLOT)) dut (
        .clk(clk), .reset(reset), .pc_ena_in(pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_tag(req_tag),
        .ram_addr_out(ram_addr_out), .ram_cmd_out(ram_cmd_out),
        .ram_addr_in(ram_addr_in), .ram_cmd_in(ram_cmd_in), .ram_data_in(ram_data_in),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_tag(rsp_tag),
        .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int issue_cyc = 0;
    int ret_seen = 0;
    int m_issued = 0;
    int m_popped = 0;
    logic        acc_last = 1'b0;
    logic        slot_edge = 1'b0;
    logic        m_hold = 1'b0;
    logic [19:0] m_addr = '0;
    logic [7:0]  m_tag = '0;
    logic [31:0] exp_cmd = '0;
    logic [19:0] exp_addr = '0;
    logic [31:0] p_cmd [3] = '{default: '0};
    logic [19:0] p_addr [3] = '{default: '0};
    logic [31:0] ret_cmd = '0;
    logic [19:0] ret_addr = '0;
    rsp_t        exp_q [$];
    rsp_t        got_q [$];
    logic [31:0] cmd_log [$];

    // Contents of the modelled RAM.
    function automatic logic [15:0] ram_data_fn(input logic [19:0] a);
        return a == 20'h00123 ? 16'hBEEF : (a[15:0] ^ {a[19:16], 12'h3C5});
    endfunction

    task automatic model_clear();
        m_hold = 1'b0;
        m_issued = 0;
        m_popped = 0;
        exp_cmd = '0;
        exp_addr = '0;
        exp_q.delete();
        got_q.delete();
    endtask

    // One clock: records handshakes, advances the request model and the RAM slot model.
    task automatic step();
        logic pre_acc, pre_pop, pre_ret;
        logic [3:0] pre_pc;
        rsp_t pre_rsp;
        pre_acc = req_valid && req_ready;
        pre_pop = rsp_valid && rsp_ready;
        pre_ret = pc == RET_SLOT && ram_cmd_in[0];
        pre_rsp = '{rsp_data, rsp_addr, rsp_tag};
        pre_pc = pc;
        @(posedge clk);
        #1;
        cyc++;
        acc_last = pre_acc;
        slot_edge = pre_pc == PC_LAST;
        if (pre_pop) begin
            got_q.push_back(pre_rsp);
            m_popped++;
        end
        if (pre_ret) ret_seen++;
        if (pre_pc == PC_LAST) begin
            exp_cmd = m_hold ? {16'h0, m_tag, 8'h01} : 32'h0;
            if (m_hold) begin
                exp_addr = m_addr;
                m_issued++;
                issue_cyc = cyc;
            end
            m_hold = 1'b0;
            cmd_log.push_back(ram_cmd_out);
        end
        if (pre_acc) begin
            m_hold = 1'b1;
            m_addr = req_addr;
            m_tag = req_tag;
            exp_q.push_back('{ram_data_fn(req_addr), req_addr, req_tag});
        end
        if (pre_pc == 0) begin
            ret_cmd = p_cmd[2];
            ret_addr = p_addr[2];
            p_cmd[2] = p_cmd[1];
            p_addr[2] = p_addr[1];
            p_cmd[1] = p_cmd[0];
            p_addr[1] = p_addr[0];
            p_cmd[0] = ram_cmd_out;
            p_addr[0] = ram_addr_out;
        end
        pc = pre_pc == PC_LAST ? 4'd0 : pre_pc + 4'd1;
        if (pc == RET_SLOT) begin
            ram_cmd_in = ret_cmd;
            ram_addr_in = ret_addr;
            ram_data_in = ram_data_fn(ret_addr);
        end else begin
            ram_cmd_in = '0;
            ram_addr_in = '0;
            ram_data_in = '0;
        end
    endtask

    task automatic send(input logic [19:0] a, input logic [7:0] t);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr = a;
        req_tag = t;
        acc_last = 1'b0;
        while (!acc_last && n < 40) begin
            step();
            n++;
        end
        req_valid = 1'b0;
        n_checks++;
        if (!acc_last) begin
            n_fail++;
            $display("FAIL send_accept addr=%h: not accepted within %0d cycles", a, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (ram_addr_out !== 20'h0 || ram_cmd_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ram_out: addr=%h cmd=%h expected 0/0", ram_addr_out, ram_cmd_out);
        end
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: rsp_valid=%b req_ready=%b expected 0/0", rsp_valid, req_ready);
        end
        n_checks++;
        if (err_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b expected 0", err_flag);
        end
        reset = 1'b0;
        model_clear();
        step();
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_single();
        int n, base, lat, hits;
        cmd_log.delete();
        rsp_ready = 1'b0;
        base = m_issued;
        send(20'h00123, 8'h5A);
        n = 0;
        while (m_issued == base && n < 10) begin
            step();
            n++;
        end
        n_checks++;
        if (ram_cmd_out !== 32'h00005A01 || ram_addr_out !== 20'h00123) begin
            n_fail++;
            $display("FAIL single_issue: cmd=%h addr=%h expected 00005a01/00123", ram_cmd_out, ram_addr_out);
        end
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        lat = cyc - issue_cyc;
        n_checks++;
        if (lat != 17) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles expected 17", lat);
        end
        n_checks++;
        if (rsp_data !== 16'hBEEF || rsp_addr !== 20'h00123 || rsp_tag !== 8'h5A) begin
            n_fail++;
            $display("FAIL single_rsp: data=%h addr=%h tag=%h expected beef/00123/5a", rsp_data, rsp_addr, rsp_tag);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        repeat (10) step();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: rsp_valid=%b expected 0", rsp_valid);
        end
        hits = 0;
        foreach (cmd_log[i]) if (cmd_log[i] == 32'h00005A01) hits++;
        n_checks++;
        if (hits != 1) begin
            n_fail++;
            $display("FAIL single_cmd_periods: got %0d periods expected 1", hits);
        end
    endtask

    task automatic test_back_to_back();
        int n, first, valid_cnt;
        logic seen_ready;
        logic [31:0] ec;
        cmd_log.delete();
        got_q.delete();
        exp_q.delete();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(20'h10 + 20'(i), 8'hA0 + 8'(i));
        req_valid = 1'b1;
        req_addr = 20'h14;
        req_tag = 8'hA4;
        seen_ready = 1'b0;
        repeat (40) begin
            step();
            if (req_ready) seen_ready = 1'b1;
        end
        req_valid = 1'b0;
        n_checks++;
        if (seen_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ready_low: got ready=1 expected 0 while 4 in flight");
        end
        first = -1;
        valid_cnt = 0;
        foreach (cmd_log[i]) if (cmd_log[i][0]) begin
            valid_cnt++;
            if (first < 0) first = i;
        end
        n_checks++;
        if (valid_cnt != 4) begin
            n_fail++;
            $display("FAIL b2b_issue_count: got %0d expected 4", valid_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            ec = {16'h0, 8'hA0 + 8'(k), 8'h01};
            n_checks++;
            if (first < 0 || first + k >= cmd_log.size() || cmd_log[first + k] !== ec) begin
                n_fail++;
                $display("FAIL b2b_issue_%0d: period %0d cmd mismatch expected %h", k, first + k, ec);
            end
        end
        rsp_ready = 1'b1;
        n = 0;
        while (got_q.size() < 4 && n < 20) begin
            step();
            n++;
        end
        rsp_ready = 1'b0;
        n_checks++;
        if (got_q.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_rsp_count: got %0d expected 4", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < 4; k++) begin
            n_checks++;
            if (got_q[k].addr !== 20'h10 + 20'(k) || got_q[k].tag !== 8'hA0 + 8'(k) ||
                got_q[k].data !== ram_data_fn(20'h10 + 20'(k))) begin
                n_fail++;
                $display("FAIL b2b_rsp_%0d: got %h/%h/%h expected addr %h", k,
                         got_q[k].data, got_q[k].addr, got_q[k].tag, 20'h10 + 20'(k));
            end
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_back: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_idle();
        int bad_cmd, bad_rsp, bad_rdy;
        cmd_log.delete();
        bad_cmd = 0;
        bad_rsp = 0;
        bad_rdy = 0;
        repeat (50) begin
            step();
            if (rsp_valid !== 1'b0) bad_rsp++;
            if (req_ready !== 1'b1) bad_rdy++;
        end
        foreach (cmd_log[i]) if (cmd_log[i] !== 32'h0) bad_cmd++;
        n_checks++;
        if (bad_cmd != 0 || cmd_log.size() != 10) begin
            n_fail++;
            $display("FAIL idle_cmd: %0d nonzero of %0d periods expected 0 of 10", bad_cmd, cmd_log.size());
        end
        n_checks++;
        if (bad_rsp != 0 || bad_rdy != 0) begin
            n_fail++;
            $display("FAIL idle_state: rsp_valid cycles=%0d ready-low cycles=%0d expected 0/0", bad_rsp, bad_rdy);
        end
    endtask

    task automatic test_push_pop();
        int n, base;
        got_q.delete();
        exp_q.delete();
        rsp_ready = 1'b0;
        base = ret_seen;
        for (int i = 0; i < 4; i++) send(20'h200 + 20'(i), 8'h30 + 8'(i));
        n = 0;
        while (ret_seen - base < 3 && n < 100) begin
            step();
            n++;
        end
        n = 0;
        while (!(pc == RET_SLOT && ram_cmd_in[0]) && n < 20) begin
            step();
            n++;
        end
        n_checks++;
        if (!(pc == RET_SLOT && ram_cmd_in[0])) begin
            n_fail++;
            $display("FAIL pushpop_fourth_return: not seen within bound");
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_checks++;
        if (got_q.size() != 1 || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pushpop_edge: popped %0d rsp_valid=%b expected 1/1", got_q.size(), rsp_valid);
        end
        rsp_ready = 1'b1;
        n = 0;
        while (rsp_valid === 1'b1 && n < 20) begin
            step();
            n++;
        end
        rsp_ready = 1'b0;
        n_checks++;
        if (got_q.size() != 4) begin
            n_fail++;
            $display("FAIL pushpop_remaining: got %0d after edge expected 3", got_q.size() - 1);
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k] || got_q[k].addr !== 20'h200 + 20'(k)) begin
                n_fail++;
                $display("FAIL pushpop_order_%0d: got %h expected %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_random();
        logic exp_ready;
        int bad_rdy, bad_cmd;
        got_q.delete();
        exp_q.delete();
        bad_rdy = 0;
        bad_cmd = 0;
        repeat (400) begin
            if (!req_valid && $urandom_range(0, 2) == 0) begin
                req_valid = 1'b1;
                req_addr = 20'($urandom);
                req_tag = 8'($urandom);
            end
            rsp_ready = $urandom_range(0, 2) == 0;
            step();
            if (acc_last) req_valid = 1'b0;
            exp_ready = !m_hold && (m_issued - m_popped) < RSP_DEPTH;
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                bad_rdy++;
                if (bad_rdy < 5) $display("FAIL rand_ready cyc %0d: got %b expected %b", cyc, req_ready, exp_ready);
            end
            if (slot_edge) begin
                n_checks++;
                if (ram_cmd_out !== exp_cmd || ram_addr_out !== exp_addr) begin
                    n_fail++;
                    bad_cmd++;
                    if (bad_cmd < 5) $display("FAIL rand_issue cyc %0d: got %h/%h expected %h/%h",
                                              cyc, ram_cmd_out, ram_addr_out, exp_cmd, exp_addr);
                end
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (60) step();
        rsp_ready = 1'b0;
        n_checks++;
        if (got_q.size() != exp_q.size() || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rand_count: got %0d responses expected %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            n_checks++;
            if (got_q[k] !== exp_q[k]) begin
                n_fail++;
                $display("FAIL rand_rsp_%0d: got %h expected %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_stray();
        int n, bad_rsp;
        got_q.delete();
        n = 0;
        while (pc != RET_SLOT && n < 10) begin
            step();
            n++;
        end
        ram_cmd_in = 32'h00000001;
        ram_addr_in = 20'h00777;
        ram_data_in = 16'hDEAD;
        bad_rsp = 0;
        repeat (10) begin
            step();
            if (rsp_valid !== 1'b0) bad_rsp++;
        end
        n_checks++;
        if (bad_rsp != 0) begin
            n_fail++;
            $display("FAIL stray_rsp: rsp_valid seen %0d cycles expected 0", bad_rsp);
        end
        n_checks++;
        if (err_flag !== ERR_EN) begin
            n_fail++;
            $display("FAIL stray_err: got %b expected %b", err_flag, ERR_EN);
        end
    endtask

    task automatic test_reset_mid();
        int n, base, bad_rsp;
        rsp_ready = 1'b0;
        base = m_issued;
        send(20'h300, 8'h71);
        send(20'h301, 8'h72);
        n = 0;
        while (m_issued - base < 2 && n < 20) begin
            step();
            n++;
        end
        n_checks++;
        if (m_issued - base < 2) begin
            n_fail++;
            $display("FAIL resetmid_setup: issued %0d expected 2", m_issued - base);
        end
        reset = 1'b1;
        model_clear();
        step();
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || err_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL resetmid_release: ready=%b rsp_valid=%b err=%b expected 1/0/0", req_ready, rsp_valid, err_flag);
        end
        bad_rsp = 0;
        repeat (40) begin
            step();
            if (rsp_valid !== 1'b0) bad_rsp++;
        end
        n_checks++;
        if (bad_rsp != 0) begin
            n_fail++;
            $display("FAIL resetmid_discard: rsp_valid seen %0d cycles expected 0", bad_rsp);
        end
        n_checks++;
        if (err_flag !== ERR_EN) begin
            n_fail++;
            $display("FAIL resetmid_err: got %b expected %b", err_flag, ERR_EN);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_idle();
        test_push_pop();
        test_random();
        test_stray();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
